// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into instruction words, buffered in a 2-entry FIFO with address tags.
// Optional immediate range checking is enabled with the ENC_RANGE_CHECK_EN macro.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_opcode,
  output logic        err_range
);
  logic        is_r, is_i, is_s, is_b, is_u, is_j, is_sh, known;
  logic        acc, push, pop;
  logic [31:0] word;
  logic [63:0] m0_q, m0_d, m1_q, m1_d;
  logic [1:0]  cnt_q, cnt_d, cnt_s;
  logic [31:0] addr_q, addr_d;
  logic        err_opcode_q, err_opcode_d;
  assign is_r  = opcode == 7'b0110011;
  assign is_i  = opcode == 7'b0010011 || opcode == 7'b0000011 || opcode == 7'b1100111 || opcode == 7'b1110011;
  assign is_s  = opcode == 7'b0100011;
  assign is_b  = opcode == 7'b1100011;
  assign is_u  = opcode == 7'b0110111 || opcode == 7'b0010111;
  assign is_j  = opcode == 7'b1101111;
  assign is_sh = opcode == 7'b0010011 && (funct3 == 3'b001 || funct3 == 3'b101);
  assign known = is_r | is_i | is_s | is_b | is_u | is_j;
  assign word = is_r  ? {funct7, rs2, rs1, funct3, rd, opcode} :
                is_sh ? {funct7, imm[4:0], rs1, funct3, rd, opcode} :
                is_i  ? {imm[11:0], rs1, funct3, rd, opcode} :
                is_s  ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                is_b  ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
                is_u  ? {imm[31:12], rd, opcode} :
                        {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
  assign in_ready  = cnt_q != 2'd2;
  assign acc       = in_valid & in_ready;
  assign push      = acc & known;
  assign out_valid = cnt_q != 2'd0;
  assign pop       = out_valid & out_ready;
  // Pop shifts the tail into the head first; a push then lands in the first free slot.
  assign cnt_s  = cnt_q - {1'b0, pop};
  assign m0_d   = push && cnt_s == 2'd0 ? {word, addr_q} : pop ? m1_q : m0_q;
  assign m1_d   = push && cnt_s == 2'd1 ? {word, addr_q} : m1_q;
  assign cnt_d  = cnt_s + {1'b0, push};
  assign addr_d = push ? addr_q + 32'd4 : addr_q;
  assign err_opcode_d = err_opcode_q | (acc & ~known);
  assign out_instr  = m0_q[63:32];
  assign out_addr   = m0_q[31:0];
  assign err_opcode = err_opcode_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_q         <= '0;
      m1_q         <= '0;
      cnt_q        <= '0;
      addr_q       <= BASE_ADDR;
      err_opcode_q <= 1'b0;
    end else begin
      m0_q         <= m0_d;
      m1_q         <= m1_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      err_opcode_q <= err_opcode_d;
    end
  end
`ifdef ENC_RANGE_CHECK_EN
  logic range_bad, err_range_q, err_range_d;
  assign range_bad = ((is_i | is_s) & (imm[31:11] != {21{imm[11]}})) |
                     (is_b & (imm[0] | (imm[31:12] != {20{imm[12]}}))) |
                     (is_j & (imm[0] | (imm[31:20] != {12{imm[20]}}))) |
                     (is_u & (imm[11:0] != 12'd0));
  assign err_range_d = err_range_q | (push & range_bad);
  assign err_range   = err_range_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_range_q <= 1'b0;
    else err_range_q <= err_range_d;
  end
`else
  assign err_range = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with directed vectors.
module tb_instr_encoder;
  logic        clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [6:0]  opcode = 0, funct7 = 0;
  logic [2:0]  funct3 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0, out_instr, out_addr, exp_addr = 0;
  logic        err_opcode, err_range;
  logic [63:0] q[$];
  int          passed = 0, total = 0;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_opcode(err_opcode), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_word", out_instr, 32'hxxxxxxxx);
      else begin
        logic [63:0] e;
        e = q.pop_front();
        chk("sb_instr", out_instr, e[63:32]);
        chk("sb_addr", out_addr, e[31:0]);
      end
    end
  end

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic [31:0] exp_instr, input bit known);
    int n = 0;
    opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    else begin
      @(posedge clk);
      if (known) begin q.push_back({exp_instr, exp_addr}); exp_addr += 4; end
    end
    #1 in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    q.delete();
    exp_addr = 0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err_opcode", {31'd0, err_opcode}, 32'd0);
    chk("rst_err_range", {31'd0, err_range}, 32'd0);
    @(posedge clk); #1 rst = 0;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    @(negedge clk); #1;
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_instr", out_instr, 32'h00500093);
    chk("lat_addr", out_addr, 32'h0);
    send(7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd2, 32'd8, 32'h0021A423, 1);
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1);
    repeat (2) @(posedge clk); #1;
    send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 0);
    chk("unk_err_opcode", {31'd0, err_opcode}, 32'd1);
    chk("unk_out_valid", {31'd0, out_valid}, 32'd0);
    send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1);
    chk("unk_addr_kept", out_addr, 32'hC);
    send(7'h13, 3'd5, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3, 32'h40335293, 1);
    send(7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h12345000, 32'h123453B7, 1);
    send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1);
    chk("legal_err_range", {31'd0, err_range}, 32'd0);
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h80000093, 1);
`ifdef ENC_RANGE_CHECK_EN
    chk("range_err", {31'd0, err_range}, 32'd1);
`else
    chk("range_err", {31'd0, err_range}, 32'd0);
`endif
    drain();
    do_reset();
    out_ready = 0;
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1);
    send(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    fork
      send(7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, 32'h00300193, 1);
      begin
        repeat (2) @(posedge clk); #1;
        chk("held_in_ready", {31'd0, in_ready}, 32'd0);
        chk("held_head", out_instr, 32'h00100093);
        out_ready = 1;
      end
    join
    drain();
    out_ready = 0;
    send(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 0);
    send(7'h13, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd4, 32'h00400213, 1);
    send(7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd5, 32'h00500293, 1);
    chk("pre_rst_err_opcode", {31'd0, err_opcode}, 32'd1);
    rst = 1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_err_opcode", {31'd0, err_opcode}, 32'd0);
    q.delete();
    exp_addr = 0;
    @(posedge clk); #1 rst = 0;
    out_ready = 1;
    send(7'h13, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd6, 32'h00600313, 1);
    chk("post_rst_addr", out_addr, 32'h0);
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 BASE_ADDR, default 32'h0000_0000, address tagged on the first encoded word after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  field bundle valid.
REQ-005 in_ready  output  1  encoder can accept a bundle this cycle.
REQ-006 opcode  input  7  RV32I major opcode.
REQ-007 funct3  input  3  / funct7  input  7  function fields.
REQ-008 rd, rs1, rs2  input  5 each  register specifiers.
REQ-009 imm  input  32  unscrambled, sign-extended immediate value.
REQ-010 out_valid  output  1  FIFO head holds an encoded word.
REQ-011 out_ready  input  1  consumer takes head this cycle.
REQ-012 out_instr  output  32  encoded instruction word at FIFO head.
REQ-013 out_addr  output  32  address tagged to out_instr.
REQ-014 err_opcode  output  1  sticky: unknown opcode accepted and dropped.
REQ-015 err_range  output  1  sticky: immediate not representable in its format.

Function
REQ-016 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-017 Format by opcode: 0110011 R; 0010011/0000011/1100111/1110011 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; any other opcode unknown.
REQ-018 Bit packing is the exact inverse of RV32I decode: opcode [6:0], rd [11:7] (R/I/U/J), funct3 [14:12] (R/I/S/B), rs1 [19:15] (R/I/S/B), rs2 [24:20] (R/S/B), funct7 [31:25] (R).
REQ-019 Immediates: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7]; U imm[31:12]->[31:12]; J imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12].
REQ-020 Shift-immediate (opcode 0010011, funct3 001 or 101): [31:25]=funct7, [24:20]=imm[4:0].
REQ-021 Encoded words go into a 2-entry FIFO; in_ready = (occupancy < 2), independent of in_valid.
REQ-022 Latency: word accepted at edge N is visible on out_instr/out_valid after edge N (one cycle) when FIFO was empty.
REQ-023 Push and pop in same cycle at occupancy 1: occupancy stays 1, order preserved; at occupancy 2 no push occurs.
REQ-024 Address counter starts at BASE_ADDR, tags each enqueued word, increments by 4 per enqueue, wraps modulo 2^32.
REQ-025 Unknown opcode: handshake completes, nothing enqueued, counter unchanged, err_opcode set.
REQ-026 Sticky flags clear only on reset.

Reset
REQ-027 On rst: FIFO empty, out_valid 0, out_instr 0, out_addr 0, counter = BASE_ADDR, err_opcode 0, err_range 0, in_ready 1 once rst deasserts.
REQ-028 rst mid-operation discards all buffered words immediately; no partial word emerges.

Configuration
REQ-029 Macro ENC_RANGE_CHECK_EN defined: check I/S imm sign-extends from bit 11; B imm[0]==0 and sign-extends from bit 12; J imm[0]==0 and sign-extends from bit 20; U imm[11:0]==0; violation sets err_range, word still encoded truncated and enqueued.
REQ-030 Macro undefined: no checks synthesized, err_range tied 0.

Verification
REQ-031 addi x1,x0,5 (0010011, rd1, f3 0, imm 5), BASE_ADDR 0 -> out_instr 0x00500093, out_addr 0x0, one cycle later.
REQ-032 sw x2,8(x3) (0100011, f3 010, rs1 3, rs2 2, imm 8) -> 0x0021A423; beq x0,x0,-4 (imm 0xFFFFFFFC) -> 0xFE000EE3.
REQ-033 out_ready 0, three back-to-back bundles -> in_ready low after second, third held; raise out_ready -> three words in order, addrs 0x0, 0x4, 0x8.
REQ-034 opcode 7'h7F -> accepted, err_opcode 1, out_valid stays 0, next valid word tagged address unchanged.
REQ-035 addi x1,x0 imm 0x800 -> out_instr 0x80000093; err_range 1 with ENC_RANGE_CHECK_EN, 0 without.
REQ-036 rst pulse with 2 words buffered -> out_valid 0 same cycle, next word tagged BASE_ADDR, flags cleared.
